// File: rtl/coeff_loader.sv
// ---------------------------------------------------------------------------
// coeff_loader
//   Write-side master for coeff_memory. Collects MSB-first serial words from
//   the frame-aligned coefficient stream and writes them to consecutive
//   addresses 0..NUM_COEFF-1, then raises load_done for the main controller.
//
// Ports
//   Sclk          in   system clock, all logic on posedge
//   Reset_n       in   synchronous active-low reset
//   start         in   1-cycle pulse, begins a load (accepted in IDLE/DONE)
//   bit_en        in   1-cycle strobe, sdata/frame valid this cycle
//   frame         in   high with bit_en on the MSB of each word
//   sdata         in   serial data bit
//   write_enable  out  1-cycle write strobe to coeff_memory
//   coeffwrite    out  write address (held after the strobe)
//   in_data       out  write data (held after the strobe)
//   busy          out  high in WAIT_FRAME/SHIFT/WRITE
//   load_done     out  high in DONE until next start or reset
//   frame_err     out  1-cycle pulse, frame seen mid-word
//   checksum      out  (COEFF_CHECKSUM_EN only) mod 2**DATA_W sum of words
//
// Configuration
//   COEFF_CHECKSUM_EN : adds the checksum output and its accumulator.
// ---------------------------------------------------------------------------
module coeff_loader #(
    parameter int NUM_COEFF = 512,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16
) (
    input  logic              Sclk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              bit_en,
    input  logic              frame,
    input  logic              sdata,
    output logic              write_enable,
    output logic [ADDR_W-1:0] coeffwrite,
    output logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              load_done,
    output logic              frame_err
`ifdef COEFF_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int          CNT_W     = $clog2(DATA_W + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_COEFF - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FRAME,
        S_SHIFT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   shift_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                busy_q;
    logic                done_q;
    logic                ferr_q;

    // Shift register with the current bit appended, and the value used when a
    // framed bit opens a fresh word.
    logic [DATA_W-1:0]   shift_d;
    logic [DATA_W-1:0]   first_d;
    logic                start_ok;

    assign shift_d  = {shift_q[DATA_W-2:0], sdata};
    assign first_d  = {{(DATA_W-1){1'b0}}, sdata};
    assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);

    always_ff @(posedge Sclk) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            // Strobes default low; address/data registers hold.
            we_q   <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q   <= S_WAIT_FRAME;
                        addr_q    <= '0;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end

                S_WAIT_FRAME: begin
                    // Unframed bits are dropped while hunting for sync.
                    if (bit_en && frame) begin
                        shift_q   <= first_d;
                        bit_cnt_q <= CNT_W'(1);
                        state_q   <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (bit_en) begin
                        if (frame) begin
                            // Frame mid-word: drop the partial word and
                            // restart on this bit; the address is not consumed.
                            ferr_q    <= 1'b1;
                            shift_q   <= first_d;
                            bit_cnt_q <= CNT_W'(1);
                        end else begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            if (bit_cnt_q == LAST_BIT) begin
                                we_q    <= 1'b1;
                                waddr_q <= addr_q;
                                wdata_q <= shift_d;
                                state_q <= S_WRITE;
                            end
                        end
                    end
                end

                S_WRITE: begin
                    if (addr_q == LAST_ADDR) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1);
                        // A framed bit landing here opens the next word so
                        // back-to-back streams lose nothing.
                        if (bit_en && frame) begin
                            shift_q   <= first_d;
                            bit_cnt_q <= CNT_W'(1);
                            state_q   <= S_SHIFT;
                        end else begin
                            bit_cnt_q <= '0;
                            state_q   <= S_WAIT_FRAME;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef COEFF_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    // Accumulates on the write strobe cycle, so it covers every word written.
    always_ff @(posedge Sclk) begin
        if (!Reset_n) begin
            csum_q <= '0;
        end else if (start_ok) begin
            csum_q <= '0;
        end else if (we_q) begin
            csum_q <= csum_q + wdata_q;
        end
    end

    assign checksum = csum_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

    assign write_enable = we_q;
    assign coeffwrite   = waddr_q;
    assign in_data      = wdata_q;
    assign busy         = busy_q;
    assign load_done    = done_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_coeff_loader.sv
module tb_coeff_loader;

    localparam int NUM_COEFF = 512;
    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 16;

    logic              Sclk;
    logic              Reset_n;
    logic              start;
    logic              bit_en;
    logic              frame;
    logic              sdata;
    logic              write_enable;
    logic [ADDR_W-1:0] coeffwrite;
    logic [DATA_W-1:0] in_data;
    logic              busy;
    logic              load_done;
    logic              frame_err;
`ifdef COEFF_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    coeff_loader #(.NUM_COEFF(NUM_COEFF), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Sclk         (Sclk),
        .Reset_n      (Reset_n),
        .start        (start),
        .bit_en       (bit_en),
        .frame        (frame),
        .sdata        (sdata),
        .write_enable (write_enable),
        .coeffwrite   (coeffwrite),
        .in_data      (in_data),
        .busy         (busy),
        .load_done    (load_done),
        .frame_err    (frame_err)
`ifdef COEFF_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    initial Sclk = 1'b0;
    always #5 Sclk = ~Sclk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: the load as a list of (address, word) writes.
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W+DATA_W-1:0] act_q[$];
    bit                       m_active = 0;
    int                       m_addr   = 0;
    logic [DATA_W-1:0]        m_csum   = '0;

    int ferr_cnt = 0;
    int we_dbl   = 0;
    logic we_prev = 1'b0;

    always @(posedge Sclk) begin
        if (write_enable) act_q.push_back({coeffwrite, in_data});
        if (frame_err) ferr_cnt++;
        if (write_enable && we_prev) we_dbl++;
        we_prev <= write_enable;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sampled clock: inputs change on the negedge, DUT samples the posedge.
    task automatic cyc(input logic en, input logic f, input logic d, input logic st);
        @(negedge Sclk);
        bit_en = en; frame = f; sdata = d; start = st;
        @(posedge Sclk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_pulse();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        if (!m_active) begin
            m_active = 1;
            m_addr   = 0;
            m_csum   = '0;
        end
    endtask

    // Unframed bits: always ignored outside a word.
    task automatic noise(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'($urandom), 1'b0);
    endtask

    task automatic send_bits(input logic [DATA_W-1:0] w, input int n, input bit gaps);
        for (int i = DATA_W - 1; i >= DATA_W - n; i--) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            cyc(1'b1, (i == DATA_W - 1), w[i], 1'b0);
        end
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input bit gaps);
        send_bits(w, DATA_W, gaps);
        if (m_active) begin
            exp_q.push_back({ADDR_W'(m_addr), w});
            m_csum = m_csum + w;
            m_addr++;
            if (m_addr == NUM_COEFF) m_active = 0;
        end
    endtask

    task automatic check_writes(input string tag);
        int n;
        idle(3);
        chk({tag, "_count"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_wr%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge Sclk);
        Reset_n = 1'b0; bit_en = 1'b0; frame = 1'b0; sdata = 1'b0; start = 1'b0;
        @(posedge Sclk);
        #1;
        chk("rst_we",    write_enable, 1'b0);
        chk("rst_addr",  coeffwrite,   '0);
        chk("rst_data",  in_data,      '0);
        chk("rst_busy",  busy,         1'b0);
        chk("rst_done",  load_done,    1'b0);
        chk("rst_ferr",  frame_err,    1'b0);
`ifdef COEFF_CHECKSUM_EN
        chk("rst_csum",  checksum,     '0);
`endif
        @(negedge Sclk);
        Reset_n = 1'b1;
        act_q.delete();
        exp_q.delete();
        m_active = 0;
        m_addr   = 0;
        m_csum   = '0;
    endtask

    logic [DATA_W-1:0] w;
    int                f0;

    initial begin
        Reset_n = 1'b0; start = 1'b0; bit_en = 1'b0; frame = 1'b0; sdata = 1'b0;
        idle(3);
        do_reset();

        // Single word, with the exact strobe timing.
        start_pulse();
        #1;
        chk("start_busy", busy, 1'b1);
        chk("start_done", load_done, 1'b0);
        send_word(16'hA5C3, 1'b0);
        #1;
        chk("single_we",   write_enable, 1'b1);
        chk("single_addr", coeffwrite, 9'd0);
        chk("single_data", in_data, 16'hA5C3);
        idle(1);
        #1;
        chk("single_we_low",  write_enable, 1'b0);
        chk("single_hold",    in_data, 16'hA5C3);
        chk("single_busy",    busy, 1'b1);
        check_writes("single");

        // Reset in the middle of a word; the next load starts at address 0.
        send_bits(16'h5555, 8, 1'b0);
        do_reset();
        start_pulse();
        send_word(16'h1111, 1'b1);
        check_writes("after_rst");

        // Frame error inside word 3: the next full word lands at address 3.
        for (int i = 1; i < 3; i++) begin
            send_word(16'($urandom), 1'b1);
            noise($urandom_range(0, 3));
        end
        f0 = ferr_cnt;
        send_bits(16'($urandom), 7, 1'b1);
        w = 16'($urandom);
        send_word(w, 1'b0);
        idle(1);
        chk("ferr_pulse", ferr_cnt - f0, 1);
        start_pulse();  // ignored while busy
        #1;
        chk("start_ignored_busy", busy, 1'b1);
        send_word(16'($urandom), 1'b1);
        check_writes("ferr");

        // Full load: back-to-back for the first words, random gaps afterwards.
        do_reset();
        start_pulse();
        for (int a = 0; a < NUM_COEFF; a++) begin
            if (a < 64) begin
                send_word(16'(a) ^ 16'h1234, 1'b0);
            end else begin
                send_word(16'(a) ^ 16'h1234, 1'b1);
                noise($urandom_range(0, 2));
            end
        end
        check_writes("full");
        #1;
        chk("full_done", load_done, 1'b1);
        chk("full_busy", busy, 1'b0);
        chk("full_double_we", we_dbl, 0);
`ifdef COEFF_CHECKSUM_EN
        chk("full_csum", checksum, m_csum);
`endif
        send_word(16'hBEEF, 1'b0);
        send_word(16'hCAFE, 1'b0);
        check_writes("extra");
        #1;
        chk("extra_done", load_done, 1'b1);

        // Restart from DONE; two words back-to-back with a wrapping sum.
        start_pulse();
        #1;
        chk("restart_done", load_done, 1'b0);
        chk("restart_busy", busy, 1'b1);
        send_word(16'hFFFF, 1'b0);
        send_word(16'h0002, 1'b0);
        check_writes("restart");
`ifdef COEFF_CHECKSUM_EN
        chk("csum_wrap", checksum, m_csum);
        chk("csum_wrap_const", checksum, 16'h0001);
`endif
        chk("final_ferr_total", ferr_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
